// File: rtl/apb_fifo_slave.sv
// APB responder exposing a 32-bit loopback FIFO through FSR/FWD/FRD/CTRL word registers; transfers take 2+WS cycles.
// PREADY/PRDATA are combinational (no bus pipeline); optional wait states under APB_FIFO_SLAVE_WAIT_EN.
module apb_fifo_slave #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        not_empty
);

  localparam int AW = CW - 1;
  localparam logic [CW-1:0] PTR_ONE = CW'(1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
  logic          ovf_q, ovf_d, udf_q, udf_d, not_empty_q;
  logic [31:0]   mem [DEPTH];
  logic          empty, full, wait_done, mem_we;
  logic [1:0]    reg_sel;
  logic [31:0]   fsr, ctrl_rd, rd_word;
  logic          unused_bits;

  assign unused_bits = ^{PADDR[31:4], PADDR[1:0], PWDATA};

`ifdef APB_FIFO_SLAVE_WAIT_EN
  logic [3:0] ws_q, ws_d, cnt_q, cnt_d;
  assign wait_done = (cnt_q == 4'd0);
  assign ctrl_rd   = {28'd0, ws_q};
`else
  assign wait_done = 1'b1;
  assign ctrl_rd   = 32'd0;
`endif

  assign reg_sel = PADDR[3:2];
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count   = wr_ptr_q - rd_ptr_q;

  always_comb begin
    fsr          = '0;
    fsr[0]       = empty;
    fsr[1]       = full;
    fsr[2]       = ovf_q;
    fsr[3]       = udf_q;
    fsr[4 +: CW] = count;
  end

  always_comb begin
    rd_word = '0;
    case (reg_sel)
      2'd0:    rd_word = fsr;
      2'd2:    rd_word = empty ? 32'd0 : mem[rd_ptr_q[AW-1:0]];
      2'd3:    rd_word = ctrl_rd;
      default: rd_word = '0;
    endcase
  end

  assign PREADY    = (state_q == ACCESS) && wait_done;
  assign PRDATA    = PREADY ? rd_word : 32'd0;
  assign not_empty = not_empty_q;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    mem_we   = 1'b0;
`ifdef APB_FIFO_SLAVE_WAIT_EN
    ws_d     = ws_q;
    cnt_d    = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d = ACCESS;
`ifdef APB_FIFO_SLAVE_WAIT_EN
          cnt_d   = ws_q;
`endif
        end
      end
      ACCESS: begin
        // Losing PSEL mid-transfer abandons it without any register or FIFO change.
        if (!PSEL) begin
          state_d = IDLE;
        end
`ifdef APB_FIFO_SLAVE_WAIT_EN
        else if (!wait_done) begin
          cnt_d = cnt_q - 4'd1;
        end
`endif
        else if (PENABLE) begin
          state_d = IDLE;
          case (reg_sel)
            2'd0: if (PWRITE) begin
              if (PWDATA[2]) ovf_d = 1'b0;
              if (PWDATA[3]) udf_d = 1'b0;
            end
            2'd1: if (PWRITE) begin
              if (full) begin
                ovf_d = 1'b1;
              end else begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
              end
            end
            2'd2: if (!PWRITE) begin
              if (empty) udf_d = 1'b1;
              else       rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            default: if (PWRITE) begin
`ifdef APB_FIFO_SLAVE_WAIT_EN
              ws_d = PWDATA[3:0];
`endif
              if (PWDATA[4]) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
              end
            end
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      not_empty_q <= 1'b0;
`ifdef APB_FIFO_SLAVE_WAIT_EN
      ws_q        <= 4'd0;
      cnt_q       <= 4'd0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
      not_empty_q <= !empty;
`ifdef APB_FIFO_SLAVE_WAIT_EN
      ws_q        <= ws_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  // Storage is deliberately left out of reset; the pointers alone define validity.
  always_ff @(posedge PCLK) begin
    if (mem_we && PRESET) mem[wr_ptr_q[AW-1:0]] <= PWDATA;
  end

endmodule

// File: tb/tb_apb_fifo_slave.sv
// Scoreboard bench for apb_fifo_slave: the driver queues expected read data and transfer length,
// the monitor pops one entry per completed APB transfer.
module tb_apb_fifo_slave;

  logic        PCLK = 1'b0;
  logic        PRESET, PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, not_empty;

  apb_fifo_slave #(.DEPTH(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .not_empty(not_empty)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    bit          is_rd;
    logic [31:0] data;
    int          cyc;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   compares = 0;
  int   fails    = 0;
  int   cur_ws   = 0;
  int   mon_cyc  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compares++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge PCLK) begin
    if (PRESET && PSEL && !PENABLE) begin
      mon_cyc = 1;
    end else if (PRESET && PSEL && PENABLE) begin
      mon_cyc++;
      if (PREADY) begin
        if (exp_q.size() == 0) begin
          compares++;
          fails++;
          $display("FAIL unexpected_completion: got transfer want none");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk({e.name, "_cycles"}, mon_cyc, e.cyc);
          if (e.is_rd) chk(e.name, PRDATA, e.data);
        end
      end else begin
        chk("prdata_zero_in_wait", PRDATA, 32'd0);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the completing edge.
  task automatic apb_xfer(input bit wr, input logic [1:0] sel, input logic [31:0] wdata,
                          input logic [31:0] exp, input string name);
    exp_t e;
    int   n;
    e.is_rd = !wr;
    e.data  = exp;
    e.cyc   = 2 + cur_ws;
    e.name  = name;
    exp_q.push_back(e);
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = wr;
    PADDR   = 32'h4000_0100 + {28'd0, sel, 2'b00};
    PWDATA  = wdata;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    n = 0;
    @(negedge PCLK);
    while (!PREADY && n < 40) begin
      n++;
      @(negedge PCLK);
    end
    if (!PREADY) begin
      compares++;
      fails++;
      $display("FAIL %s_timeout: got PREADY=0 want 1", name);
    end
    @(posedge PCLK); #1;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
  endtask

  task automatic wr_reg(input logic [1:0] sel, input logic [31:0] data, input string name);
    apb_xfer(1'b1, sel, data, 32'd0, name);
`ifdef APB_FIFO_SLAVE_WAIT_EN
    if (sel == 2'd3) cur_ws = int'(data[3:0]);
`endif
  endtask

  task automatic rd_reg(input logic [1:0] sel, input logic [31:0] exp, input string name);
    apb_xfer(1'b0, sel, 32'd0, exp, name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    fails++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $fatal(1, "watchdog expired");
  end

  initial begin
    PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 32'd0; PWDATA = 32'd0;
    repeat (3) @(posedge PCLK);
    #1;
    chk("reset_pready", {31'd0, PREADY}, 32'd0);
    chk("reset_prdata", PRDATA, 32'd0);
    chk("reset_not_empty", {31'd0, not_empty}, 32'd0);
    PRESET = 1'b1;
    @(negedge PCLK);
    chk("idle_pready", {31'd0, PREADY}, 32'd0);
    @(posedge PCLK); #1;

    rd_reg(2'd0, 32'h0000_0001, "fsr_after_reset");

    // In-order loopback of three words, back-to-back transfers.
    wr_reg(2'd1, 32'hA5A5_0001, "push1");
    wr_reg(2'd1, 32'hA5A5_0002, "push2");
    wr_reg(2'd1, 32'hA5A5_0003, "push3");
    rd_reg(2'd0, 32'h0000_0030, "fsr_count3");
    chk("not_empty_after_push", {31'd0, not_empty}, 32'd1);
    rd_reg(2'd2, 32'hA5A5_0001, "pop1");
    rd_reg(2'd2, 32'hA5A5_0002, "pop2");
    rd_reg(2'd2, 32'hA5A5_0003, "pop3");
    chk("not_empty_at_pop_edge", {31'd0, not_empty}, 32'd1);
    @(posedge PCLK); #1;
    chk("not_empty_one_cycle_later", {31'd0, not_empty}, 32'd0);
    rd_reg(2'd0, 32'h0000_0001, "fsr_count0");

    // Overflow: 17 pushes into 16 entries, last word dropped.
    for (int i = 0; i < 17; i++) wr_reg(2'd1, 32'h1000_0000 + i, "push_fill");
    rd_reg(2'd0, 32'h0000_0106, "fsr_full_ovf");
    wr_reg(2'd0, 32'h0000_0004, "clr_ovf");
    rd_reg(2'd0, 32'h0000_0102, "fsr_full_only");
    for (int i = 0; i < 16; i++) rd_reg(2'd2, 32'h1000_0000 + i, "pop_drain");
    rd_reg(2'd0, 32'h0000_0001, "fsr_drained");

    // Underflow on empty FIFO.
    rd_reg(2'd2, 32'h0000_0000, "pop_empty");
    rd_reg(2'd0, 32'h0000_0009, "fsr_udf");
    wr_reg(2'd0, 32'h0000_0008, "clr_udf");
    rd_reg(2'd0, 32'h0000_0001, "fsr_udf_cleared");
    rd_reg(2'd1, 32'h0000_0000, "fwd_read_zero");

    // Wait states.
    wr_reg(2'd3, 32'h0000_0003, "ctrl_ws3");
`ifdef APB_FIFO_SLAVE_WAIT_EN
    rd_reg(2'd3, 32'h0000_0003, "ctrl_readback");
`else
    rd_reg(2'd3, 32'h0000_0000, "ctrl_readback");
`endif
    rd_reg(2'd0, 32'h0000_0001, "fsr_with_ws");
    wr_reg(2'd3, 32'h0000_0000, "ctrl_ws0");

    // Flush.
    for (int i = 0; i < 5; i++) wr_reg(2'd1, 32'h5500_0000 + i, "push_flush");
    rd_reg(2'd0, 32'h0000_0050, "fsr_count5");
    wr_reg(2'd3, 32'h0000_0010, "ctrl_flush");
    chk("not_empty_at_flush_edge", {31'd0, not_empty}, 32'd1);
    @(posedge PCLK); #1;
    chk("not_empty_after_flush", {31'd0, not_empty}, 32'd0);
    rd_reg(2'd0, 32'h0000_0001, "fsr_flushed");
    rd_reg(2'd3, 32'h0000_0000, "ctrl_flush_selfclear");

    // Reset pulse during a push: no entry, FSM back in IDLE, WS cleared.
`ifdef APB_FIFO_SLAVE_WAIT_EN
    wr_reg(2'd3, 32'h0000_0003, "ctrl_ws3_again");
`endif
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
    PADDR = 32'h4000_0104; PWDATA = 32'hDEAD_BEEF;
`ifdef APB_FIFO_SLAVE_WAIT_EN
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
`endif
    PRESET = 1'b0;
    @(posedge PCLK); #1;
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0;
    cur_ws = 0;
    @(negedge PCLK);
    chk("pready_after_abort", {31'd0, PREADY}, 32'd0);
    chk("not_empty_after_abort", {31'd0, not_empty}, 32'd0);
    @(posedge PCLK); #1;
    rd_reg(2'd0, 32'h0000_0001, "fsr_after_abort");
    rd_reg(2'd3, 32'h0000_0000, "ctrl_after_abort");

    repeat (2) @(posedge PCLK);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule

// File: doc/apb_fifo_slave.md
# apb_fifo_slave

APB responder peripheral on the APB bus, selected by one PSELx line of the APB master's decoder. It exposes a 32-bit-wide, DEPTH-entry loopback FIFO through four word registers. Slave-inserted wait states are programmable. Words pushed by one bus write are returned in order by later bus reads, so the block also serves as a system scratch queue and as a bring-up target for the master's handshake.

## Interface
- DEPTH, 16: FIFO entries; must be a power of two, 2..256.
- CW, $clog2(DEPTH)+1: count width.
- PCLK  in  1  rising-edge clock.
- PRESET  in  1  reset, synchronous, active-low.
- PSEL  in  1  slave select from the APB master decoder.
- PENABLE  in  1  APB access-phase flag.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  32  byte address; only PADDR[3:2] are decoded, all other bits ignored.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data; 0 whenever PREADY is 0.
- PREADY  out  1  transfer completes on the edge where PSEL & PENABLE & PREADY = 1.
- not_empty  out  1  registered FIFO-not-empty flag for interrupt or polling use.

## Operation
- Register map, PADDR[3:2]:
  - 0 FSR, status, read/W1C: [0] empty, [1] full, [2] overflow sticky, [3] underflow sticky, [4+CW-1:4] count, other bits 0. Writing 1 to bit 2 or bit 3 clears that bit; all other write bits are ignored.
  - 1 FWD, write-only: a write pushes PWDATA. A read returns 0 and has no side effect.
  - 2 FRD, read-only: a read returns the head entry and pops it. A write is ignored.
  - 3 CTRL, read/write: [3:0] wait count WS; [4] flush, which is self-clearing and always reads 0. Other bits read 0.
- FSM states are IDLE and ACCESS.
  - IDLE -> ACCESS when PSEL=1 and PENABLE=0 (setup phase). The wait counter loads WS on this transition.
  - ACCESS, counter != 0: PREADY=0 and the counter decrements.
  - ACCESS, counter == 0: PREADY=1. All side effects commit on this edge, then the FSM returns to IDLE.
  - ACCESS with PSEL=0: protocol abort. The FSM returns to IDLE with no side effects.
- Push to a full FIFO: data dropped, overflow set, pointers unchanged.
- Pop from an empty FIFO: PRDATA=0, underflow set, pointers unchanged.
- Pointers are CW bits wide and wrap modulo 2*DEPTH. Full is defined as pointer MSBs differ while the low bits are equal.
- count = wr_ptr - rd_ptr, taken modulo 2^CW.
- Flush (CTRL[4]=1 written): both pointers are zeroed on the completing edge. The sticky bits are unaffected. WS takes the written value in the same edge.
- A write to CTRL changes WS for later transfers only; the transfer in progress keeps its loaded count.

## Timing
- Reset, on the rising PCLK edge with PRESET=0:
  - FSM to IDLE, pointers 0, sticky bits 0, WS 0, wait counter 0.
  - Outputs: PREADY=0, PRDATA=0, not_empty=0.
  - Reset mid-transfer abandons the transfer with no side effect. Memory contents are not cleared.
- PREADY and PRDATA are combinational from FSM state, counter, address and FIFO head. No bus-side pipeline register is allowed.
- Latency: a transfer occupies 2+WS cycles (setup, WS wait cycles, final access). WS=0 gives the zero-wait case.
- PRDATA is valid only in the cycle PREADY=1; the FRD value is mem[rd_ptr] in that cycle.
- not_empty is a register that reflects the FIFO state one cycle after the completing edge.
- Back-to-back transfers (the next setup in the cycle after completion) are accepted with no idle gap.

## Configuration
- APB_FIFO_SLAVE_WAIT_EN
  - Defined: behaviour is as described above, with WS programmable via CTRL[3:0].
  - Undefined: the wait counter logic is removed. CTRL[3:0] reads 0 and writes to it are ignored. PREADY=1 in every ACCESS cycle, so every transfer takes exactly 2 cycles. CTRL[4] flush still works.

## Test plan
- Reset, then read FSR -> 0x0000_0001 (empty=1, count=0). not_empty=0 and PREADY=0 while idle.
- Write FWD 0xA5A5_0001, 0xA5A5_0002, 0xA5A5_0003, then read FRD three times -> data returned in the same order. FSR count goes 3 -> 0; not_empty falls one cycle after the third pop.
- Push DEPTH+1 words -> FSR = full | overflow | count=DEPTH (0x0000_0106 with DEPTH=16). The extra word is lost. Write 0x4 to FSR -> overflow cleared, full stays set.
- Read FRD on an empty FIFO -> PRDATA=0 and FSR bit 3 set. Write 0x8 to FSR -> FSR reads 0x0000_0001.
- Write CTRL=0x3, then read FSR -> PREADY is low for 3 access cycles and high in the 4th, 5 cycles total. Repeat with the macro undefined -> 2 cycles, and CTRL reads 0x0.
- Push 5 words, write CTRL=0x10 (flush) -> FSR = 0x0000_0001 and not_empty=0. Pulse PRESET low during the wait cycles of a push -> no entry added and the FSM is in IDLE.
